inst_pair_buffer: RTL and testbench
===================================

Name: inst_pair_buffer

Overview:
- Decoupling queue between instruction fetch and the dual-issue stage.
- Accepts 64-bit fetch packets, each holding two 32-bit instructions.
- Presents the two oldest instructions and their PCs as slot 0 and slot 1 to issue.
- Pops 0, 1 or 2 entries per cycle, as directed by issue's stall and special-stall outputs. After a 1-pop, the unissued slot-1 instruction re-presents as slot 0, paired with the next queued instruction.

Parameters:
- DEPTH, 8: number of 32-bit instruction entries. Power of 2, DEPTH >= 4.
- NOP, 32'h00000013: instruction driven on an empty or invalid slot (addi x0,x0,0).

Ports:
- clock_i  in  1  core clock; all state updates on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- flush_i  in  1  redirect; discards all queued entries.
- fetch_valid_i  in  1  fetch packet present this cycle.
- fetch_inst0_i  in  32  older instruction of the packet.
- fetch_inst1_i  in  32  younger instruction of the packet.
- fetch_pc_i  in  32  PC of fetch_inst0_i; fetch_inst1_i is at fetch_pc_i+4.
- fetch_ready_o  out  1  at least 2 free entries.
- issue_stall_i  in  1  downstream stall; pop nothing.
- issue1_special_stall_i  in  1  issue keeps slot 1; pop slot 0 only.
- inst0_o  out  32  oldest instruction, or NOP.
- inst1_o  out  32  second-oldest instruction, or NOP.
- pc0_o  out  32  PC of inst0_o, 0 when invalid.
- pc1_o  out  32  PC of inst1_o, 0 when invalid.
- valid0_o  out  1  inst0_o is real.
- valid1_o  out  1  inst1_o is real.
- count_o  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular array of DEPTH entries, each {inst[31:0], pc[31:0]}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Outputs, all combinational from registered state:
  - valid0_o = (count >= 1); valid1_o = (count >= 2).
  - inst0_o/pc0_o = entry[head]; inst1_o/pc1_o = entry[head+1 mod DEPTH].
  - An invalid slot drives NOP and pc 0.
- fetch_ready_o = (DEPTH - count) >= 2. It depends only on registered count, never on the same-cycle pop.
- push = fetch_valid_i && fetch_ready_o. It writes inst0 at tail and inst1 at tail+1, with pcs fetch_pc_i and fetch_pc_i+4 (32-bit wrap). tail += 2.
- fetch_valid_i while not ready: the packet is dropped; fetch must hold it. This is a protocol error for the verifier to flag.
- pop count:
  - issue_stall_i = 1: 0.
  - else issue1_special_stall_i = 1: valid0_o (0 or 1).
  - else: valid0_o + valid1_o.
  - head += pop.
- count_next = count + 2*push - pop. Simultaneous push and pop in one cycle is legal. Push only targets free entries, so a pop never reads a same-cycle write.
- Empty: valid0/1 = 0, NOPs out, pop = 0 regardless of inputs. A push becomes visible the next cycle (1-cycle fetch-to-issue latency).
- One entry: only slot 0 valid; a pop removes 1 even without special stall.
- flush_i: next cycle head = tail = count = 0. Flush wins over push and pop in the same cycle; the pushed packet is discarded.
- reset_n_i low at a clock edge: head = tail = count = 0, so fetch_ready_o = 1, valid0/1 = 0, inst0/1 = NOP, pc0/1 = 0.
  - Reset mid-operation discards contents identically to flush.
  - Storage array contents are not reset.
- Program order is preserved. Slot 0 is always older than slot 1, which the issue dependency check requires.

Test Plan:
- Reset, then push {inst0=0x00100093, inst1=0x00200113, pc=0x100}, no stall -> next cycle: valid0=valid1=1, pc0=0x100, pc1=0x104. Following cycle: count=0, inst0_o=inst1_o=0x00000013.
- Push pkts A(0x100), B(0x108) back-to-back, issue1_special_stall_i=1 on first issue cycle -> slot0=0x100 popped. Next cycle slot0=pc 0x104, slot1=pc 0x108, count=3.
- Fill DEPTH=8 with 4 packets, no pops -> count=8, fetch_ready_o=0. A fifth fetch_valid_i is ignored. One 2-pop makes fetch_ready_o=1 the next cycle.
- Pushes and 2-pops every cycle for 20 cycles -> pointers wrap, PCs increase by 4 with no gap or duplicate, count stays 2.
- Count=5 with push and flush_i in the same cycle -> next cycle count=0, valid0=0, fetch_ready_o=1.
- Count=1 with issue_stall_i=1 -> no pop, count stays 1. With stall released, no special stall -> pop 1, count=0.

Source files
------------

// File: rtl/inst_pair_buffer.sv
// Instruction pair buffer: decouples 64-bit fetch packets from a dual-issue stage.
// Presents the two oldest queued instructions each cycle and retires 0, 1 or 2.
module inst_pair_buffer #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_inst0_i,
  input  logic [31:0]              fetch_inst1_i,
  input  logic [31:0]              fetch_pc_i,
  output logic                     fetch_ready_o,
  input  logic                     issue_stall_i,
  input  logic                     issue1_special_stall_i,
  output logic [31:0]              inst0_o,
  output logic [31:0]              inst1_o,
  output logic [31:0]              pc0_o,
  output logic [31:0]              pc1_o,
  output logic                     valid0_o,
  output logic                     valid1_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic          push;
  logic [1:0]    pop_cnt;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  assign valid0_o = (count_q != '0);
  assign valid1_o = (count_q >= CW'(2));

  // Readiness looks only at registered occupancy so fetch never sees a
  // combinational path from the issue stall inputs.
  assign fetch_ready_o = (count_q <= CW'(DEPTH - 2));
  assign push          = fetch_valid_i && fetch_ready_o;

  assign inst0_o = valid0_o ? inst_mem[head_q]  : NOP;
  assign pc0_o   = valid0_o ? pc_mem[head_q]    : 32'd0;
  assign inst1_o = valid1_o ? inst_mem[head_p1] : NOP;
  assign pc1_o   = valid1_o ? pc_mem[head_p1]   : 32'd0;
  assign count_o = count_q;

  always_comb begin
    pop_cnt = 2'd0;
    if (!issue_stall_i) begin
      if (issue1_special_stall_i) begin
        pop_cnt = {1'b0, valid0_o};
      end else begin
        pop_cnt = {1'b0, valid0_o} + {1'b0, valid1_o};
      end
    end
  end

  always_comb begin
    head_d  = head_q + AW'(pop_cnt);
    tail_d  = push ? (tail_q + AW'(2)) : tail_q;
    count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; a write during flush lands in space that the
  // cleared pointers already treat as free.
  always_ff @(posedge clock_i) begin
    if (push) begin
      inst_mem[tail_q]  <= fetch_inst0_i;
      pc_mem[tail_q]    <= fetch_pc_i;
      inst_mem[tail_p1] <= fetch_inst1_i;
      pc_mem[tail_p1]   <= fetch_pc_i + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_pair_buffer.sv
// Scoreboard bench for inst_pair_buffer: a queue of {inst, pc} mirrors the
// expected buffer contents and every cycle's slot outputs are checked against it.
module tb_inst_pair_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_inst0 = '0;
  logic [31:0] fetch_inst1 = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready;
  logic        issue_stall = 1'b0;
  logic        special_stall = 1'b0;
  logic [31:0] inst0, inst1, pc0, pc1;
  logic        valid0, valid1;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  logic [63:0] sb[$];
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  inst_pair_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clock_i                (clk),
    .reset_n_i              (reset_n),
    .flush_i                (flush),
    .fetch_valid_i          (fetch_valid),
    .fetch_inst0_i          (fetch_inst0),
    .fetch_inst1_i          (fetch_inst1),
    .fetch_pc_i             (fetch_pc),
    .fetch_ready_o          (fetch_ready),
    .issue_stall_i          (issue_stall),
    .issue1_special_stall_i (special_stall),
    .inst0_o                (inst0),
    .inst1_o                (inst1),
    .pc0_o                  (pc0),
    .pc1_o                  (pc1),
    .valid0_o               (valid0),
    .valid1_o               (valid1),
    .count_o                (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL txn %0d %s: got 0x%08h, expected 0x%08h", txn, tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the scoreboard, drive inputs, then
  // advance the scoreboard to what the DUT should hold after the next edge.
  task automatic step(input logic fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pcv, input logic st, input logic ss,
                      input logic fl, input logic rs);
    logic [63:0] e0, e1;
    int          sz, npop;
    bit          ready;
    @(negedge clk);
    sz = sb.size();
    e0 = (sz >= 1) ? sb[0] : {NOP, 32'd0};
    e1 = (sz >= 2) ? sb[1] : {NOP, 32'd0};
    ready = (DEPTH - sz) >= 2;
    check_eq("valid0", {31'd0, valid0}, (sz >= 1) ? 32'd1 : 32'd0);
    check_eq("valid1", {31'd0, valid1}, (sz >= 2) ? 32'd1 : 32'd0);
    check_eq("inst0", inst0, e0[63:32]);
    check_eq("pc0", pc0, e0[31:0]);
    check_eq("inst1", inst1, e1[63:32]);
    check_eq("pc1", pc1, e1[31:0]);
    check_eq("count", {28'd0, count}, sz);
    check_eq("fetch_ready", {31'd0, fetch_ready}, ready ? 32'd1 : 32'd0);

    fetch_valid   = fv;
    fetch_inst0   = i0;
    fetch_inst1   = i1;
    fetch_pc      = pcv;
    issue_stall   = st;
    special_stall = ss;
    flush         = fl;
    reset_n       = ~rs;

    if (rs || fl) begin
      sb.delete();
      npop = 0;
    end else begin
      if (st)      npop = 0;
      else if (ss) npop = (sz >= 1) ? 1 : 0;
      else         npop = (sz >= 2) ? 2 : sz;
      repeat (npop) void'(sb.pop_front());
      if (fv && ready) begin
        sb.push_back({i0, pcv});
        sb.push_back({i1, pcv + 32'd4});
      end
    end
    $display("txn %0d: fv=%0b pc=0x%08h st=%0b ss=%0b fl=%0b rs=%0b held=%0d pop=%0d next=%0d",
             txn, fv, pcv, st, ss, fl, rs, sz, npop, sb.size());
    txn++;
  endtask

  task automatic idle(input logic st);
    step(1'b0, '0, '0, '0, st, 1'b0, 1'b0, 1'b0);
  endtask

  // Push a packet with instruction words derived from the PC.
  task automatic push_pc(input logic [31:0] pcv, input logic st, input logic ss, input logic fl);
    step(1'b1, pcv ^ 32'hA5000000, (pcv + 32'd4) ^ 32'h5A000000, pcv, st, ss, fl, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);

    // Single packet, issued as a pair, then buffer empties.
    step(1'b1, 32'h00100093, 32'h00200113, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Special stall retires slot 0 only; slot 1 moves up to slot 0.
    push_pc(32'h200, 1'b0, 1'b0, 1'b0);
    push_pc(32'h208, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Fill to full, attempt a dropped push, then one 2-pop frees space.
    for (int i = 0; i < 4; i++) push_pc(32'h1000 + 32'(i * 8), 1'b1, 1'b0, 1'b0);
    push_pc(32'h2000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    repeat (4) idle(1'b0);

    // Streaming push + 2-pop for 20 cycles, pointers wrap several times.
    for (int i = 0; i < 20; i++) push_pc(32'h3000 + 32'(i * 8), 1'b0, 1'b0, 1'b0);
    repeat (2) idle(1'b0);

    // Build count 5, then push and flush together.
    push_pc(32'h4000, 1'b0, 1'b0, 1'b0);
    push_pc(32'h4008, 1'b0, 1'b1, 1'b0);
    push_pc(32'h4010, 1'b1, 1'b0, 1'b0);
    push_pc(32'h4018, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // Single entry: stall holds it, unstalled pop removes just one.
    push_pc(32'h5000, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Reset in the middle of operation discards contents.
    push_pc(32'h6000, 1'b1, 1'b0, 1'b0);
    push_pc(32'h6008, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h11111111, 32'h22222222, 32'h7000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // Random traffic including wrap-around of the 32-bit PC.
    next_pc = 32'hFFFFFF80;
    for (int i = 0; i < 60; i++) begin
      logic fv, st, ss, fl;
      fv = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 4) == 0);
      ss = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 19) == 0);
      step(fv, $urandom, $urandom, next_pc, st, ss, fl, 1'b0);
      if (fv && (DEPTH - count) >= 2) next_pc = next_pc + 32'd8;
    end
    repeat (5) idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
